// File: rtl/me_pkg.sv
// me_pkg: shared motion-estimation widths, constants and sequencer state encoding.
package me_pkg;
  localparam int SW_LENGTH = 32;
  localparam int TB_LENGTH = 8;
  localparam int SAD_W = 16;
  localparam int MVEC_W = 10;
  localparam int BLK_W = 6;
  localparam logic [SAD_W-1:0] MAX_SAD = 16'hFFFF;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_WAIT_ACK_LOW = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
endpackage

// File: rtl/me_result_slot.sv
// me_result_slot: one-entry valid/ready holding register for ME block results.
module me_result_slot
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ready,
  input  logic [SAD_W-1:0]  sad_in,
  input  logic [MVEC_W-1:0] mvec_in,
  input  logic [BLK_W-1:0]  bx_in,
  input  logic [BLK_W-1:0]  by_in,
  output logic              full,
  output logic              empty,
  output logic              drain,
  output logic [SAD_W-1:0]  sad,
  output logic [MVEC_W-1:0] mvec,
  output logic [BLK_W-1:0]  bx,
  output logic [BLK_W-1:0]  by
);
  assign empty = !full;
  assign drain = full && ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full <= 1'b0;
      sad  <= MAX_SAD;
      mvec <= '0;
      bx   <= '0;
      by   <= '0;
    end else if (load) begin
      full <= 1'b1;
      sad  <= sad_in;
      mvec <= mvec_in;
      bx   <= bx_in;
      by   <= by_in;
    end else if (drain) begin
      full <= 1'b0;
    end
endmodule

// File: rtl/me_frame_sequencer.sv
// me_frame_sequencer: raster-order block walker driving the ME core req/ack handshake.
// Optional ack timeout enabled by defining ME_SEQ_TIMEOUT_EN.
module me_frame_sequencer
  import me_pkg::*;
#(
  parameter int FRAME_W_BLK    = 4,
  parameter int FRAME_H_BLK    = 3,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BLK_W-1:0]  blk_x,
  output logic [BLK_W-1:0]  blk_y,
  output logic              me_req,
  input  logic              me_ack,
  input  logic [SAD_W-1:0]  me_min_sad,
  input  logic [MVEC_W-1:0] me_min_mvec,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SAD_W-1:0]  res_sad,
  output logic [MVEC_W-1:0] res_mvec,
  output logic [BLK_W-1:0]  res_blk_x,
  output logic [BLK_W-1:0]  res_blk_y
);
  localparam logic [BLK_W-1:0] LAST_X = BLK_W'(FRAME_W_BLK - 1);
  localparam logic [BLK_W-1:0] LAST_Y = BLK_W'(FRAME_H_BLK - 1);
  logic [2:0] state;
  logic slot_empty, slot_drain, room, load, timeout, last_x, last_y;
  assign room   = slot_empty || slot_drain;
  assign load   = state == S_WAIT_ACK && me_ack;
  assign last_x = blk_x == LAST_X;
  assign last_y = blk_y == LAST_Y;
`ifdef ME_SEQ_TIMEOUT_EN
  logic [11:0] cnt;
  assign timeout = state == S_WAIT_ACK && !me_ack && cnt == 12'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= state == S_WAIT_ACK ? cnt + 12'd1 : 12'd0;
      err <= (state == S_IDLE && start) ? 1'b0 : (timeout ? 1'b1 : err);
    end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= S_IDLE;
      blk_x  <= '0;
      blk_y  <= '0;
      me_req <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          blk_x <= '0;
          blk_y <= '0;
          busy  <= 1'b1;
          state <= S_ISSUE;
        end
        S_ISSUE: if (room) begin
          me_req <= 1'b1;
          state  <= S_WAIT_ACK;
        end
        S_WAIT_ACK: if (me_ack || timeout) begin
          me_req <= 1'b0;
          state  <= me_ack ? S_WAIT_ACK_LOW : S_DRAIN;
        end
        S_WAIT_ACK_LOW: if (!me_ack) begin
          blk_x <= last_x ? '0 : blk_x + 1'b1;
          blk_y <= last_x ? (last_y ? '0 : blk_y + 1'b1) : blk_y;
          state <= (last_x && last_y) ? S_DRAIN : S_ISSUE;
        end
        S_DRAIN: if (room) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  me_result_slot u_slot (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .ready  (res_ready),
    .sad_in (me_min_sad),
    .mvec_in(me_min_mvec),
    .bx_in  (blk_x),
    .by_in  (blk_y),
    .full   (res_valid),
    .empty  (slot_empty),
    .drain  (slot_drain),
    .sad    (res_sad),
    .mvec   (res_mvec),
    .bx     (res_blk_x),
    .by     (res_blk_y)
  );
endmodule

// File: tb/tb_me_frame_sequencer.sv
// tb_me_frame_sequencer: scoreboard bench for a 2x2 frame with a scripted ME core model.
module tb_me_frame_sequencer;
  import me_pkg::*;
  localparam int W = 2;
  localparam int H = 2;
  localparam int TO = 20;
  typedef struct packed {
    logic [15:0] sad;
    logic [9:0]  mvec;
    logic [5:0]  x;
    logic [5:0]  y;
  } res_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, me_ack = 1'b0, res_ready = 1'b1;
  logic [15:0] me_min_sad = '0;
  logic [9:0] me_min_mvec = '0;
  logic busy, done, err, me_req, res_valid;
  logic [5:0] blk_x, blk_y, res_blk_x, res_blk_y;
  logic [15:0] res_sad;
  logic [9:0] res_mvec;
  res_t exp_q[$];
  res_t mon_e;
  int compared = 0, mismatched = 0, res_count = 0;
  logic [5:0] ex = '0, ey = '0;
  me_frame_sequencer #(.FRAME_W_BLK(W), .FRAME_H_BLK(H), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .blk_x(blk_x), .blk_y(blk_y), .me_req(me_req), .me_ack(me_ack),
    .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec), .res_valid(res_valid),
    .res_ready(res_ready), .res_sad(res_sad), .res_mvec(res_mvec),
    .res_blk_x(res_blk_x), .res_blk_y(res_blk_y)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
      compared++;
      res_count++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL result_unexpected: got sad=%h at (%0d,%0d), required no result", res_sad, res_blk_x, res_blk_y);
      end else begin
        mon_e = exp_q.pop_front();
        if ({res_sad, res_mvec, res_blk_x, res_blk_y} !== mon_e) begin
          mismatched++;
          $display("FAIL result_data: got sad=%h mvec=%h (%0d,%0d), required sad=%h mvec=%h (%0d,%0d)",
                   res_sad, res_mvec, res_blk_x, res_blk_y, mon_e.sad, mon_e.mvec, mon_e.x, mon_e.y);
        end
      end
    end
  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ex = '0;
    ey = '0;
  endtask
  task automatic serve(input int delay, input int hold);
    int n;
    logic [15:0] s;
    logic [9:0] m;
    n = 0;
    while (me_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (me_req !== 1'b1) begin
      mismatched++;
      $display("FAIL req_wait: me_req=%b, required 1", me_req);
      return;
    end
    compared++;
    if ({blk_x, blk_y} !== {ex, ey}) begin
      mismatched++;
      $display("FAIL req_coord: got (%0d,%0d), required (%0d,%0d)", blk_x, blk_y, ex, ey);
    end
    repeat (delay) @(negedge clk);
    s = 16'($urandom);
    m = 10'($urandom);
    me_min_sad = s;
    me_min_mvec = m;
    me_ack = 1'b1;
    exp_q.push_back({s, m, ex, ey});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (me_req !== 1'b0 && n < 200);
    compared++;
    if (n !== 1 || res_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL ack_latency: req drop after %0d cycles valid=%b, required 1 cycle valid=1", n, res_valid);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      compared++;
      if (me_req !== 1'b0 || {blk_x, blk_y} !== {ex, ey}) begin
        mismatched++;
        $display("FAIL ack_hold: req=%b blk=(%0d,%0d), required req=0 blk=(%0d,%0d)", me_req, blk_x, blk_y, ex, ey);
      end
    end
    me_ack = 1'b0;
    if (ex == 6'(W - 1)) begin
      ex = '0;
      ey = (ey == 6'(H - 1)) ? 6'd0 : ey + 6'd1;
    end else ex = ex + 6'd1;
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL frame_done: done=%b busy=%b, required done=1 busy=0", done, busy);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if ({busy, done, err, me_req, res_valid} !== 5'b0 || {blk_x, blk_y, res_blk_x, res_blk_y} !== 24'b0 ||
        res_sad !== 16'hFFFF || res_mvec !== 10'b0) begin
      mismatched++;
      $display("FAIL reset_values: ctl=%b blk=%h sad=%h mvec=%h, required ctl=0 blk=0 sad=ffff mvec=0",
               {busy, done, err, me_req, res_valid}, {blk_x, blk_y, res_blk_x, res_blk_y}, res_sad, res_mvec);
    end
    rst = 1'b0;
  endtask
  task automatic test_frame();
    int c0;
    c0 = res_count;
    res_ready = 1'b1;
    start_frame();
    compared++;
    if (busy !== 1'b1 || me_req !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL start_accept: busy=%b req=%b err=%b, required 1 0 0", busy, me_req, err);
    end
    @(negedge clk);
    compared++;
    if (me_req !== 1'b1) begin
      mismatched++;
      $display("FAIL first_req: me_req=%b, required 1", me_req);
    end
    for (int b = 0; b < W * H; b++) serve(5, 0);
    @(negedge clk);
    compared++;
    if (done !== 1'b0 || res_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL last_drain: done=%b valid=%b, required 0 0", done, res_valid);
    end
    @(negedge clk);
    compared++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL done_pulse: done=%b busy=%b, required 1 0", done, busy);
    end
    @(negedge clk);
    compared++;
    if (done !== 1'b0 || busy !== 1'b0 || res_count - c0 !== W * H || exp_q.size() !== 0) begin
      mismatched++;
      $display("FAIL frame_end: done=%b busy=%b results=%0d pending=%0d, required 0 0 %0d 0",
               done, busy, res_count - c0, exp_q.size(), W * H);
    end
  endtask
  task automatic test_backpressure();
    res_ready = 1'b0;
    start_frame();
    serve(2, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      compared++;
      if (me_req !== 1'b0 || res_valid !== 1'b1 || res_sad !== exp_q[0].sad || res_mvec !== exp_q[0].mvec) begin
        mismatched++;
        $display("FAIL stall_hold: req=%b valid=%b sad=%h mvec=%h, required 0 1 %h %h",
                 me_req, res_valid, res_sad, res_mvec, exp_q[0].sad, exp_q[0].mvec);
      end
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (me_req !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_release: me_req=%b, required 1", me_req);
    end
    for (int b = 1; b < W * H; b++) serve(3, 0);
    wait_done();
  endtask
  task automatic test_ack_hold();
    res_ready = 1'b1;
    start_frame();
    serve(1, 10);
    @(negedge clk);
    compared++;
    if (me_req !== 1'b0 || blk_x !== 6'd1 || blk_y !== 6'd0) begin
      mismatched++;
      $display("FAIL ack_low_advance: req=%b blk=(%0d,%0d), required req=0 blk=(1,0)", me_req, blk_x, blk_y);
    end
    @(negedge clk);
    compared++;
    if (me_req !== 1'b1) begin
      mismatched++;
      $display("FAIL ack_low_reissue: me_req=%b, required 1", me_req);
    end
    for (int b = 1; b < W * H; b++) serve(1, 0);
    wait_done();
  endtask
  task automatic test_start_ignored();
    int c0;
    c0 = res_count;
    res_ready = 1'b1;
    start_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    compared++;
    if (me_req !== 1'b1 || blk_x !== 6'd0 || blk_y !== 6'd0) begin
      mismatched++;
      $display("FAIL start_in_wait: req=%b blk=(%0d,%0d), required req=1 blk=(0,0)", me_req, blk_x, blk_y);
    end
    for (int b = 0; b < W * H; b++) serve(2, 0);
    wait_done();
    @(negedge clk);
    compared++;
    if (res_count - c0 !== W * H || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL start_ignored_count: results=%0d busy=%b, required %0d 0", res_count - c0, busy, W * H);
    end
  endtask
  task automatic test_reset_mid();
    int n;
    res_ready = 1'b1;
    start_frame();
    serve(1, 0);
    n = 0;
    while (me_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (me_req !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || blk_x !== 6'd0 || blk_y !== 6'd0) begin
      mismatched++;
      $display("FAIL reset_mid_wait: req=%b valid=%b busy=%b blk=(%0d,%0d), required 0 0 0 (0,0)",
               me_req, res_valid, busy, blk_x, blk_y);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    res_ready = 1'b0;
    start_frame();
    serve(1, 0);
    #2 rst = 1'b1;
    #1;
    compared++;
    if (res_valid !== 1'b0 || res_sad !== 16'hFFFF || res_mvec !== 10'd0) begin
      mismatched++;
      $display("FAIL reset_full_slot: valid=%b sad=%h mvec=%h, required 0 ffff 0", res_valid, res_sad, res_mvec);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    res_ready = 1'b1;
  endtask
`ifdef ME_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n, c0;
    c0 = res_count;
    res_ready = 1'b1;
    start_frame();
    n = 0;
    while (me_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (me_req === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n !== TO || err !== 1'b1 || res_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_req: req high %0d cycles err=%b valid=%b, required %0d 1 0", n, err, res_valid, TO);
    end
    wait_done();
    compared++;
    if (res_count !== c0 || exp_q.size() !== 0) begin
      mismatched++;
      $display("FAIL timeout_no_result: results=%0d, required 0", res_count - c0);
    end
    start_frame();
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_err_clear: err=%b, required 0", err);
    end
    for (int b = 0; b < W * H; b++) serve(2, 0);
    wait_done();
  endtask
`endif
  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_ack_hold();
    test_start_ignored();
    test_reset_mid();
    test_frame();
`ifdef ME_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
